// File: rtl/button_event_arbiter.sv
// Routes debounced button presses through a small event FIFO to whichever of menu/game owns input.
// Optional auto-repeat while a button is held is enabled by defining BTN_AUTOREPEAT_EN.
module button_event_arbiter #(
    parameter int FIFO_DEPTH    = 4,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          btn_up,
    input  logic                          btn_down,
    input  logic                          btn_left,
    input  logic                          btn_right,
    input  logic                          game_active,
    input  logic                          game_exit_req,
    output logic                          menu_evt_valid,
    output logic [1:0]                    menu_evt_code,
    input  logic                          menu_evt_ready,
    output logic                          game_evt_valid,
    output logic [1:0]                    game_evt_code,
    input  logic                          game_evt_ready,
    output logic                          owner,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [1:0]                    arb_state
);
    // Event ports use valid/ready: a code is transferred on a cycle where valid and ready are
    // both high; once valid rises, valid and code hold until that transfer happens.

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two in 2..16");
    end
    if (REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_repeat
        $error("REPEAT_DELAY must be >= REPEAT_PERIOD >= 1");
    end

    typedef enum logic [1:0] {
        OWN_MENU = 2'd0,
        SWITCH   = 2'd1,
        OWN_GAME = 2'd2
    } state_t;

    state_t          state;
    logic            owner_q;
    logic            overflow_q;
    logic            exit_pend;
    logic [3:0]      prev_lvl;
    logic [3:0]      pending;
    logic [1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [LW-1:0]   level;

    logic [3:0]      btn_vec;
    logic [3:0]      rise;
    logic [3:0]      rpt;
    logic [3:0]      push_oh;
    logic [1:0]      push_code;
    logic [1:0]      head;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            pop;
    logic            stall;
    logic            switch_req;
    logic            leave;

    assign btn_vec    = {btn_right, btn_left, btn_down, btn_up};
    assign rise       = btn_vec & ~prev_lvl;
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LW'(FIFO_DEPTH));
    assign head       = mem[rd_ptr];

    assign menu_evt_valid = (state == OWN_MENU) && !fifo_empty;
    assign game_evt_valid = (state == OWN_GAME) && !fifo_empty;
    assign menu_evt_code  = menu_evt_valid ? head : 2'd0;
    assign game_evt_code  = game_evt_valid ? head : 2'd0;

    assign pop   = (menu_evt_valid & menu_evt_ready) | (game_evt_valid & game_evt_ready);
    assign stall = (menu_evt_valid & ~menu_evt_ready) | (game_evt_valid & ~game_evt_ready);

    // Lowest set bit wins: up beats down beats left beats right.
    assign push_oh = pending & (~pending + 4'd1);
    assign push    = (state != SWITCH) && (pending != 4'd0) && (!fifo_full || pop);

    always_comb begin
        push_code = 2'd0;
        casez (pending)
            4'b???1: push_code = 2'd0;
            4'b??10: push_code = 2'd1;
            4'b?100: push_code = 2'd2;
            4'b1000: push_code = 2'd3;
            default: push_code = 2'd0;
        endcase
    end

    // The game's exit pulse is remembered so a stalled handshake cannot lose it.
    always_comb begin
        switch_req = 1'b0;
        case (state)
            OWN_MENU: switch_req = game_active;
            OWN_GAME: switch_req = game_exit_req | exit_pend | ~game_active;
            default:  switch_req = 1'b0;
        endcase
    end

    assign leave = switch_req && !stall;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= OWN_MENU;
            owner_q    <= 1'b0;
            overflow_q <= 1'b0;
            exit_pend  <= 1'b0;
            prev_lvl   <= 4'hF;
            pending    <= 4'd0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
        end else begin
            prev_lvl <= btn_vec;
            if (state == SWITCH) begin
                // FIFO was emptied on entry; edges seen during this cycle belong to the new owner.
                state   <= owner_q ? OWN_MENU : OWN_GAME;
                owner_q <= ~owner_q;
                pending <= rise | rpt;
            end else if (leave) begin
                state     <= SWITCH;
                exit_pend <= 1'b0;
                pending   <= 4'd0;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                level     <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                level      <= level + LW'(push) - LW'(pop);
                pending    <= (pending & ~(push ? push_oh : 4'd0)) | (rise & ~pending) | rpt;
                overflow_q <= overflow_q | (|(rise & pending));
                exit_pend  <= exit_pend | ((state == OWN_GAME) & game_exit_req);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push && !leave) mem[wr_ptr] <= push_code;
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RW-1:0] hold_cnt [4];

    always_comb begin
        rpt = 4'd0;
        for (int i = 0; i < 4; i++) begin
            rpt[i] = btn_vec[i] & prev_lvl[i] & (state != SWITCH) & (hold_cnt[i] == RPT_LAST);
        end
    end

    // Counter holds cycles since press; after each repeat it reloads so the next fires one period later.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < 4; i++) hold_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!btn_vec[i] || rise[i] || state == SWITCH) hold_cnt[i] <= '0;
                else if (rpt[i])                             hold_cnt[i] <= RPT_RELOAD;
                else                                         hold_cnt[i] <= hold_cnt[i] + 1'b1;
            end
        end
    end
`else
    assign rpt = 4'd0;
`endif

    assign owner      = owner_q;
    assign fifo_level = level;
    assign overflow   = overflow_q;
    assign arb_state  = state;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: a queue-based reference model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_button_event_arbiter;
  localparam int DEPTH = 4;
  localparam int RDLY  = 8;
  localparam int RPER  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       btn_up, btn_down, btn_left, btn_right;
  logic       game_active, game_exit_req;
  logic       menu_evt_valid, menu_evt_ready;
  logic [1:0] menu_evt_code;
  logic       game_evt_valid, game_evt_ready;
  logic [1:0] game_evt_code;
  logic       owner, overflow;
  logic [2:0] fifo_level;
  logic [1:0] arb_state;

  button_event_arbiter #(
    .FIFO_DEPTH(DEPTH), .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .game_active(game_active), .game_exit_req(game_exit_req),
    .menu_evt_valid(menu_evt_valid), .menu_evt_code(menu_evt_code), .menu_evt_ready(menu_evt_ready),
    .game_evt_valid(game_evt_valid), .game_evt_code(game_evt_code), .game_evt_ready(game_evt_ready),
    .owner(owner), .fifo_level(fifo_level), .overflow(overflow), .arb_state(arb_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // reference model: queue of codes, per-button pending, ownership and a switching flag
  logic [1:0] exp_q[$];
  bit [3:0]   m_pend, m_prev;
  bit         m_own, m_sw, m_ovf, m_exit;
  int         m_age[4];

  function automatic bit repeat_due(input int age);
`ifdef BTN_AUTOREPEAT_EN
    return (age == RDLY) || (age > RDLY && ((age - RDLY) % RPER) == 0);
`else
    return (age < 0);
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pend = '0; m_prev = 4'hF; m_own = 0; m_sw = 0; m_ovf = 0; m_exit = 0;
    for (int b = 0; b < 4; b++) m_age[b] = 0;
  endtask

  task automatic model_step();
    bit [3:0] btn, rise, old, rpt;
    bit v_m, v_g, hs, req, full;
    btn  = {btn_right, btn_left, btn_down, btn_up};
    rise = btn & ~m_prev;
    v_m  = !m_sw && !m_own && exp_q.size() > 0;
    v_g  = !m_sw && m_own && exp_q.size() > 0;
    hs   = (v_m && menu_evt_ready) || (v_g && game_evt_ready);
    rpt  = '0;
    if (m_sw) begin
      m_sw = 0;
      m_own = !m_own;
      m_pend = rise;
      for (int b = 0; b < 4; b++) m_age[b] = 0;
    end else begin
      req = m_own ? (m_exit || game_exit_req || !game_active) : game_active;
      for (int b = 0; b < 4; b++) begin
        if (btn[b] && m_prev[b]) begin
          m_age[b]++;
          if (repeat_due(m_age[b])) rpt[b] = 1;
        end else m_age[b] = 0;
      end
      if (req && (hs || !(v_m || v_g))) begin
        m_sw = 1; exp_q.delete(); m_pend = '0; m_exit = 0;
      end else begin
        full = (exp_q.size() == DEPTH);
        old  = m_pend;
        if (hs) void'(exp_q.pop_front());
        if (old != 0 && (!full || hs)) begin
          for (int b = 0; b < 4; b++) if (old[b]) begin
            exp_q.push_back(2'(b)); m_pend[b] = 0; break;
          end
        end
        for (int b = 0; b < 4; b++) if (rise[b]) begin
          if (old[b]) m_ovf = 1; else m_pend[b] = 1;
        end
        m_pend |= rpt;
        if (m_own && game_exit_req) m_exit = 1;
      end
    end
    m_prev = btn;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // scoreboard compare: every cycle out of reset
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      bit ev_m, ev_g;
      ev_m = !m_sw && !m_own && exp_q.size() > 0;
      ev_g = !m_sw && m_own && exp_q.size() > 0;
      check("menu_valid", int'(menu_evt_valid), int'(ev_m));
      check("game_valid", int'(game_evt_valid), int'(ev_g));
      if (ev_m) check("menu_code", int'(menu_evt_code), int'(exp_q[0]));
      if (ev_g) check("game_code", int'(game_evt_code), int'(exp_q[0]));
      check("fifo_level", int'(fifo_level), exp_q.size());
      check("owner", int'(owner), int'(m_own));
      check("overflow", int'(overflow), int'(m_ovf));
      check("state", int'(arb_state), m_sw ? 1 : (m_own ? 2 : 0));
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int b, input bit v);
    case (b)
      0: btn_up = v;
      1: btn_down = v;
      2: btn_left = v;
      default: btn_right = v;
    endcase
  endtask

  int seq5[6] = '{0, 1, 2, 3, 0, 0};
  int n_evt;

  initial begin
    rst_n = 1'b0;
    btn_up = 0; btn_down = 0; btn_left = 1; btn_right = 0;
    game_active = 0; game_exit_req = 0; menu_evt_ready = 0; game_evt_ready = 0;
    tick(2);
    check("rst_level", int'(fifo_level), 0);
    check("rst_owner", int'(owner), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_state", int'(arb_state), 0);
    check("rst_valids", int'({menu_evt_valid, game_evt_valid}), 0);
    check("rst_codes", int'({menu_evt_code, game_evt_code}), 0);
    rst_n = 1'b1;

    // left held through reset release: no event
    tick(3);
    check("held_reset_level", int'(fifo_level), 0);
    btn_left = 0;
    tick(2);

    // single down press, ready high: valid two cycles later for one cycle
    menu_evt_ready = 1;
    btn_down = 1;
    tick(1);
    check("down_not_yet", int'(menu_evt_valid), 0);
    tick(1);
    check("down_valid", int'(menu_evt_valid), 1);
    check("down_code", int'(menu_evt_code), 1);
    check("down_level", int'(fifo_level), 1);
    tick(1);
    check("down_popped", int'(menu_evt_valid), 0);
    check("down_level0", int'(fifo_level), 0);
    btn_down = 0;
    menu_evt_ready = 0;
    tick(2);

    // up and right together: codes 0 then 3
    btn_up = 1; btn_right = 1;
    tick(3);
    check("pair_level", int'(fifo_level), 2);
    check("pair_head", int'(menu_evt_code), 0);
    btn_up = 0; btn_right = 0;
    menu_evt_ready = 1;
    tick(1);
    check("pair_second", int'(menu_evt_code), 3);
    tick(1);
    check("pair_drained", int'(fifo_level), 0);
    menu_evt_ready = 0;
    tick(2);

    // five presses into a depth-4 FIFO, then a repeat of the held one
    foreach (seq5[i]) begin
      press(seq5[i], 1); tick(1);
      press(seq5[i], 0); tick(1);
    end
    check("full_level", int'(fifo_level), 4);
    check("full_overflow", int'(overflow), 1);
    menu_evt_ready = 1;
    tick(8);
    check("full_drained", int'(fifo_level), 0);
    menu_evt_ready = 0;

    // two queued events then hand over to the game
    btn_down = 1; btn_left = 1;
    tick(3);
    check("pre_switch_level", int'(fifo_level), 2);
    btn_down = 0; btn_left = 0;
    game_active = 1; menu_evt_ready = 1;
    tick(1);
    check("switch_state", int'(arb_state), 1);
    check("switch_level", int'(fifo_level), 0);
    check("switch_valid", int'(menu_evt_valid | game_evt_valid), 0);
    menu_evt_ready = 0;
    tick(1);
    check("game_owner", int'(owner), 1);
    check("game_state", int'(arb_state), 2);
    btn_right = 1; tick(1);
    btn_right = 0; tick(1);
    check("game_valid_lit", int'(game_evt_valid), 1);
    check("game_code_lit", int'(game_evt_code), 3);
    check("menu_quiet", int'(menu_evt_valid), 0);

    // exit request while the game stalls its port
    game_exit_req = 1; tick(1);
    game_exit_req = 0; tick(2);
    check("exit_deferred", int'(arb_state), 2);
    check("exit_deferred_owner", int'(owner), 1);
    game_evt_ready = 1;
    tick(1);
    check("exit_switch", int'(arb_state), 1);
    game_active = 0; game_evt_ready = 0;
    tick(1);
    check("menu_owner", int'(owner), 0);
    check("menu_state", int'(arb_state), 0);
    tick(2);

    // long hold of left: one event, or press plus three repeats with auto-repeat
    menu_evt_ready = 1;
    btn_left = 1;
    n_evt = 0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (menu_evt_valid && menu_evt_code == 2'd2) n_evt++;
      if (i == 19) btn_left = 0;
    end
`ifdef BTN_AUTOREPEAT_EN
    check("hold_events", n_evt, 4);
`else
    check("hold_events", n_evt, 1);
`endif
    check("overflow_sticky", int'(overflow), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
